// File: rtl/gpioemu_host_if.sv
`default_nettype none
// =============================================================================
// Module   : gpioemu_host_if
// Brief    : Command/response handshake and gpioemu strobe bus bundle.
// Revision : 1.0 - initial release
// =============================================================================
interface gpioemu_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_arg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;

    // Host side: owns the bus strobes and the response channel
    modport master (
        input  cmd_valid, cmd_arg, rsp_ready, sdata_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               saddress, srd, swr, sdata_in
    );

    // Requester / register-slave side
    modport slave (
        output cmd_valid, cmd_arg, rsp_ready, sdata_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
               saddress, srd, swr, sdata_in
    );
endinterface
`default_nettype wire

// File: rtl/gpioemu_host.sv
`default_nettype none
// =============================================================================
// Module   : gpioemu_host
// Brief    : Bus initiator: writes argument to A, polls S until idle, reads W.
//            Optional poll timeout enabled by defining GPIOEMU_HOST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module gpioemu_host #(
    parameter logic [15:0] ADDR_A   = 16'h288,
    parameter logic [15:0] ADDR_W   = 16'h298,
    parameter logic [15:0] ADDR_S   = 16'h2A0,
    parameter int unsigned POLL_GAP = 8
`ifdef GPIOEMU_HOST_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT  = 4096
`endif
) (
    input  wire logic      clk,
    input  wire logic      reset,
    gpioemu_host_if.master bus
);

    localparam int unsigned c_state_w = 4;
    localparam logic [c_state_w-1:0] c_st_idle     = 4'd0;
    localparam logic [c_state_w-1:0] c_st_wr_setup = 4'd1;
    localparam logic [c_state_w-1:0] c_st_wr_stb   = 4'd2;
    localparam logic [c_state_w-1:0] c_st_wr_hold  = 4'd3;
    localparam logic [c_state_w-1:0] c_st_gap      = 4'd4;
    localparam logic [c_state_w-1:0] c_st_s_setup  = 4'd5;
    localparam logic [c_state_w-1:0] c_st_s_stb    = 4'd6;
    localparam logic [c_state_w-1:0] c_st_s_sample = 4'd7;
    localparam logic [c_state_w-1:0] c_st_w_setup  = 4'd8;
    localparam logic [c_state_w-1:0] c_st_w_stb    = 4'd9;
    localparam logic [c_state_w-1:0] c_st_w_sample = 4'd10;
    localparam logic [c_state_w-1:0] c_st_resp     = 4'd11;

    localparam logic [7:0] c_gap_last = 8'(POLL_GAP - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic [7:0]           r_gap_cnt;
    logic                 r_ready_en;
    logic [15:0]          r_saddress;
    logic [31:0]          r_sdata_in;
    logic [31:0]          r_rsp_data;

    logic w_cmd_ready;
    logic w_accept;
    logic w_gap_done;
    logic w_s_busy;
    logic w_timeout;
    logic w_srd;
    logic w_swr;
    logic w_rsp_valid;
    logic w_busy;

    assign w_accept   = bus.cmd_valid & w_cmd_ready;
    assign w_gap_done = (r_gap_cnt == c_gap_last);
    assign w_s_busy   = bus.sdata_out[0];

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:     if (w_accept) w_state_nxt = c_st_wr_setup;
            c_st_wr_setup: w_state_nxt = c_st_wr_stb;
            c_st_wr_stb:   w_state_nxt = c_st_wr_hold;
            c_st_wr_hold:  w_state_nxt = c_st_gap;
            c_st_gap:      if (w_gap_done) w_state_nxt = c_st_s_setup;
            c_st_s_setup:  w_state_nxt = c_st_s_stb;
            c_st_s_stb:    w_state_nxt = c_st_s_sample;
            c_st_s_sample: w_state_nxt = w_s_busy ? c_st_gap : c_st_w_setup;
            c_st_w_setup:  w_state_nxt = c_st_w_stb;
            c_st_w_stb:    w_state_nxt = c_st_w_sample;
            c_st_w_sample: w_state_nxt = c_st_resp;
            c_st_resp:     if (bus.rsp_ready) w_state_nxt = c_st_idle;
            default:       w_state_nxt = c_st_idle;
        endcase
        // An expired poll budget overrides wherever the poll loop currently is
        if (w_timeout) begin
            w_state_nxt = c_st_resp;
        end
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        w_swr       = 1'b0;
        w_srd       = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        w_cmd_ready = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_busy      = 1'b0;
                w_cmd_ready = r_ready_en;
            end
            c_st_wr_stb:             w_swr       = 1'b1;
            c_st_s_stb, c_st_w_stb:  w_srd       = 1'b1;
            c_st_resp:               w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    // Address/data only change on the edge that enters a SETUP state, so the
    // bus holds its last value between accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready_en <= 1'b0;
            r_gap_cnt  <= 8'd0;
            r_saddress <= 16'd0;
            r_sdata_in <= 32'd0;
            r_rsp_data <= 32'd0;
        end else begin
            r_ready_en <= 1'b1;
            r_gap_cnt  <= (r_state == c_st_gap) ? r_gap_cnt + 8'd1 : 8'd0;
            if (w_accept) begin
                r_saddress <= ADDR_A;
                r_sdata_in <= bus.cmd_arg;
            end
            if (r_state == c_st_gap && w_gap_done && !w_timeout) begin
                r_saddress <= ADDR_S;
            end
            if (r_state == c_st_s_sample && !w_s_busy && !w_timeout) begin
                r_saddress <= ADDR_W;
            end
            if (r_state == c_st_w_sample) begin
                r_rsp_data <= bus.sdata_out;
            end
            if (w_timeout) begin
                r_rsp_data <= 32'd0;
            end
        end
    end

`ifdef GPIOEMU_HOST_TIMEOUT_EN
    localparam logic [15:0] c_to_last = 16'(TIMEOUT - 1);

    logic [15:0] r_to_cnt;
    logic        r_rsp_err;
    logic        w_polling;

    assign w_polling = (r_state == c_st_gap)    || (r_state == c_st_s_setup) ||
                       (r_state == c_st_s_stb)  || (r_state == c_st_s_sample);
    assign w_timeout = w_polling && (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt  <= 16'd0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_to_cnt <= 16'd0;
            end else if (w_polling) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
            if (r_state == c_st_w_sample) begin
                r_rsp_err <= 1'b0;
            end
            if (w_timeout) begin
                r_rsp_err <= 1'b1;
            end
        end
    end

    assign bus.rsp_err = r_rsp_err;
`else
    assign w_timeout   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = w_busy;
    assign bus.saddress  = r_saddress;
    assign bus.srd       = w_srd;
    assign bus.swr       = w_swr;
    assign bus.sdata_in  = r_sdata_in;

endmodule
`default_nettype wire

// File: tb/tb_gpioemu_host.sv
`default_nettype none
// =============================================================================
// Module   : tb_gpioemu_host
// Brief    : Scoreboard bench for gpioemu_host with a gpioemu register-slave model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_gpioemu_host;

    localparam logic [15:0] c_addr_a = 16'h288;
    localparam logic [15:0] c_addr_w = 16'h298;
    localparam logic [15:0] c_addr_s = 16'h2A0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpioemu_host_if bus ();

    gpioemu_host #(
        .ADDR_A   (c_addr_a),
        .ADDR_W   (c_addr_w),
        .ADDR_S   (c_addr_s),
        .POLL_GAP (8)
`ifdef GPIOEMU_HOST_TIMEOUT_EN
        ,
        .TIMEOUT  (200)
`endif
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- slave model
    // W = A*5 + 7; S[0] reads busy for busy_reads_cfg polls after each A write.
    int          busy_reads_cfg = 0;
    logic        stuck          = 1'b0;
    int          busy_left      = 0;
    logic [31:0] w_reg          = 32'd0;

    always @(posedge clk) begin
        if (bus.swr && bus.saddress == c_addr_a) begin
            w_reg     <= bus.sdata_in * 32'd5 + 32'd7;
            busy_left <= busy_reads_cfg;
        end
        if (bus.srd) begin
            if (bus.saddress == c_addr_s) begin
                bus.sdata_out <= {31'd0, (stuck || busy_left != 0)};
                if (busy_left != 0) busy_left <= busy_left - 1;
            end else if (bus.saddress == c_addr_w) begin
                bus.sdata_out <= w_reg;
            end else begin
                bus.sdata_out <= 32'hDEAD_BEEF;
            end
        end
    end

    // ---------------------------------------------------------------- scoreboard
    logic [32:0] exp_q[$];

    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got data %0h err %0b with nothing expected",
                         bus.rsp_data, bus.rsp_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", {32'd0, bus.rsp_data}, {32'd0, e[31:0]});
                chk("rsp_err", {63'd0, bus.rsp_err}, {63'd0, e[32]});
            end
        end
    end

    // ---------------------------------------------------------------- bus checker
    int          n_wr = 0, n_s_rd = 0, n_w_rd = 0;
    logic [31:0] last_wdata = 32'd0;
    logic        prev_srd = 1'b0, prev_swr = 1'b0, hold_chk = 1'b0;
    logic [15:0] prev_addr = 16'd0, strobe_addr = 16'd0;

    always @(negedge clk) begin
        if (reset) begin
            prev_srd <= 1'b0;
            prev_swr <= 1'b0;
            hold_chk <= 1'b0;
        end else begin
            if (hold_chk) chk("addr_hold", {48'd0, bus.saddress}, {48'd0, strobe_addr});
            if (bus.srd || bus.swr) begin
                chk("strobe_excl", {63'd0, bus.srd & bus.swr}, 64'd0);
                chk("strobe_width", {63'd0, (bus.srd & prev_srd) | (bus.swr & prev_swr)}, 64'd0);
                chk("addr_setup", {48'd0, bus.saddress}, {48'd0, prev_addr});
                if (bus.swr) begin
                    chk("write_addr", {48'd0, bus.saddress}, {48'd0, c_addr_a});
                    n_wr       <= n_wr + 1;
                    last_wdata <= bus.sdata_in;
                end else if (bus.saddress == c_addr_s) begin
                    n_s_rd <= n_s_rd + 1;
                end else if (bus.saddress == c_addr_w) begin
                    n_w_rd <= n_w_rd + 1;
                end else begin
                    chk("read_addr", {48'd0, bus.saddress}, {48'd0, c_addr_s});
                end
            end
            hold_chk    <= bus.srd | bus.swr;
            strobe_addr <= bus.saddress;
            prev_srd    <= bus.srd;
            prev_swr    <= bus.swr;
            prev_addr   <= bus.saddress;
        end
    end

    // ---------------------------------------------------------------- stimulus helpers
    task automatic send_cmd(input logic [31:0] arg, output int acc_cyc);
        logic got;
        got = 1'b0;
        bus.cmd_arg   = arg;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL cmd_accept: cmd_ready never rose for arg %0h", arg);
            bus.cmd_valid = 1'b0;
            acc_cyc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc       = cyc;
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int bound);
        logic got;
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d responses still pending", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_valid(input int bound, output logic got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL rsp_valid_timeout: no response within %0d cycles", bound);
        end
    endtask

    // ---------------------------------------------------------------- main sequence
    initial begin
        int   acc, lat, wr0, s0, w0;
        logic got;
        bus.cmd_valid = 1'b0;
        bus.cmd_arg   = 32'd0;
        bus.rsp_ready = 1'b0;
        reset         = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_rsp_data",  {32'd0, bus.rsp_data},  64'd0);
        chk("rst_rsp_err",   {63'd0, bus.rsp_err},   64'd0);
        chk("rst_busy",      {63'd0, bus.busy},      64'd0);
        chk("rst_saddress",  {48'd0, bus.saddress},  64'd0);
        chk("rst_srd",       {63'd0, bus.srd},       64'd0);
        chk("rst_swr",       {63'd0, bus.swr},       64'd0);
        chk("rst_sdata_in",  {32'd0, bus.sdata_in},  64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("cmd_ready_after_reset", {63'd0, bus.cmd_ready}, 64'd1);

        // Three S polls (busy, busy, idle), then one W read: 4*5+7 = 0x1B
        busy_reads_cfg = 2;
        bus.rsp_ready  = 1'b1;
        wr0 = n_wr; s0 = n_s_rd; w0 = n_w_rd;
        exp_q.push_back({1'b0, 32'h0000_001B});
        send_cmd(32'h4, acc);
        wait_drain(300);
        chk("t1_writes",  64'(n_wr - wr0), 64'd1);
        chk("t1_wdata",   {32'd0, last_wdata}, 64'h4);
        chk("t1_s_reads", 64'(n_s_rd - s0), 64'd3);
        chk("t1_w_reads", 64'(n_w_rd - w0), 64'd1);

        // Idle on first poll: response 17 cycles after acceptance; 9*5+7 = 0x34
        busy_reads_cfg = 0;
        exp_q.push_back({1'b0, 32'h0000_0034});
        send_cmd(32'h9, acc);
        wait_rsp_valid(100, got);
        lat = cyc - acc;
        if (got) chk("t2_latency", 64'(lat), 64'd17);
        wait_drain(50);

        // Response back-pressure: 7*5+7 = 0x2A held, second command ignored
        busy_reads_cfg = 1;
        bus.rsp_ready  = 1'b0;
        exp_q.push_back({1'b0, 32'h0000_002A});
        send_cmd(32'h7, acc);
        wait_rsp_valid(200, got);
        busy_reads_cfg = 0;
        @(posedge clk);
        #1;
        wr0 = n_wr;
        bus.cmd_arg   = 32'h55;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_rsp_valid_hold", {63'd0, bus.rsp_valid}, 64'd1);
            chk("t3_rsp_data_hold",  {32'd0, bus.rsp_data},  64'h2A);
            chk("t3_cmd_ready_low",  {63'd0, bus.cmd_ready}, 64'd0);
        end
        chk("t3_no_extra_write", 64'(n_wr - wr0), 64'd0);
        // 0x55*5+7 = 0x1B0, accepted the cycle after the response handshake
        exp_q.push_back({1'b0, 32'h0000_01B0});
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_cmd_ready_after_rsp", {63'd0, bus.cmd_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        wait_drain(100);
        chk("t3_second_write", 64'(n_wr - wr0), 64'd1);
        chk("t3_second_wdata", {32'd0, last_wdata}, 64'h55);

        // Reset while in GAP; the abandoned command must produce nothing
        busy_reads_cfg = 1000;
        send_cmd(32'h99, acc);
        repeat (5) @(posedge clk);
        #1;
        chk("t4_busy_in_gap", {63'd0, bus.busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t4_srd",       {63'd0, bus.srd},       64'd0);
        chk("t4_swr",       {63'd0, bus.swr},       64'd0);
        chk("t4_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("t4_busy",      {63'd0, bus.busy},      64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // 0x14*5+7 = 0x6B
        busy_reads_cfg = 1;
        wr0 = n_wr;
        exp_q.push_back({1'b0, 32'h0000_006B});
        send_cmd(32'h14, acc);
        wait_drain(300);
        chk("t4_fresh_write", 64'(n_wr - wr0), 64'd1);
        chk("t4_fresh_wdata", {32'd0, last_wdata}, 64'h14);

        // S stuck busy
        busy_reads_cfg = 0;
        stuck = 1'b1;
        s0 = n_s_rd; w0 = n_w_rd;
`ifdef GPIOEMU_HOST_TIMEOUT_EN
        exp_q.push_back({1'b1, 32'h0000_0000});
        send_cmd(32'h21, acc);
        wait_drain(500);
        chk("t5_no_w_read", 64'(n_w_rd - w0), 64'd0);
        stuck = 1'b0;
`else
        send_cmd(32'h21, acc);
        repeat (2100) @(posedge clk);
        #1;
        chk("t5_still_busy", {63'd0, bus.busy}, 64'd1);
        chk("t5_polls_continue", {63'd0, (n_s_rd - s0) >= 180}, 64'd1);
        chk("t5_no_w_read", 64'(n_w_rd - w0), 64'd0);
        // 0x21*5+7 = 0xAC once S finally clears
        exp_q.push_back({1'b0, 32'h0000_00AC});
        stuck = 1'b0;
        wait_drain(100);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gpioemu_host.md
# gpioemu_host

Bus initiator for the gpioemu register interface: accepts a 32-bit argument on a valid/ready command port, writes it to register A, polls status register S until the computation finishes, reads the result from register W, and returns it on a response port. It drives the same saddress/srd/swr/sdata_in strobe bus that the gpioemu slave samples, and replaces hand-written bench stimulus in system-level and driver-side integration tests.

## Interface
- ADDR_A, 16'h288, argument register address (write)
- ADDR_W, 16'h298, result register address (read)
- ADDR_S, 16'h2A0, status register address (read); bit 0 = 1 means computation busy
- POLL_GAP, 8, idle cycles between consecutive S reads (1..255)
- TIMEOUT, 4096, max poll cycles before abort (only with timeout feature)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_arg  in  32  argument written to A
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  response accepted
- rsp_data  out  32  value read from W
- rsp_err  out  1  1 = timeout abort, rsp_data = 0
- busy  out  1  high in any state other than IDLE
- saddress  out  16  bus address
- srd  out  1  read strobe, single-cycle pulse
- swr  out  1  write strobe, single-cycle pulse
- sdata_in  out  32  write data to slave
- sdata_out  in  32  read data from slave

## Operation
- States: IDLE, WR_SETUP, WR_STB, WR_HOLD, GAP, S_SETUP, S_STB, S_SAMPLE, W_SETUP, W_STB, W_SAMPLE, RESP.
- IDLE: cmd_valid & cmd_ready -> capture cmd_arg, go WR_SETUP.
- Write access: WR_SETUP drives saddress=ADDR_A, sdata_in=arg; WR_STB asserts swr; WR_HOLD keeps address/data, swr=0; then GAP.
- GAP: counts POLL_GAP cycles, then S_SETUP.
- Read access (S or W): SETUP drives address; STB asserts srd; SAMPLE captures sdata_out.
- S_SAMPLE: sdata_out[0]=1 -> GAP (poll again); 0 -> W_SETUP.
- W_SAMPLE: rsp_data <= sdata_out, rsp_err <= 0, go RESP.
- RESP: rsp_valid=1 until rsp_valid & rsp_ready, then IDLE. rsp_data/rsp_err stable while rsp_valid.
- swr and srd never high in the same cycle; never high outside STB states.
- saddress and sdata_in hold last value outside accesses (no glitching to 0).
- cmd_valid while busy is ignored (cmd_ready=0); no queuing.

## Timing
- Reset values: cmd_ready=0 in the reset cycle then 1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, saddress=0, srd=0, swr=0, sdata_in=0; FSM -> IDLE, counters cleared.
- Reset mid-operation: next cycle FSM in IDLE, strobes low, pending response discarded.
- Write: strobe on cycle 2 after acceptance; address/data valid 1 cycle before and 1 cycle after swr.
- Read: slave returns sdata_out one cycle after srd; sampled in SAMPLE state.
- Minimum latency cmd accept -> rsp_valid (S idle on first poll): 3 + POLL_GAP + 3 + 3 cycles = 17 for POLL_GAP=8.
- Each additional poll adds POLL_GAP + 3 cycles.
- rsp_valid & rsp_ready in the same cycle as cmd_valid: response completes, cmd_ready rises next cycle; command accepted the cycle after.

## Configuration
- GPIOEMU_HOST_TIMEOUT_EN defined: 16-bit counter counts cycles spent in GAP/S_* states; reaching TIMEOUT goes to RESP with rsp_err=1, rsp_data=0, W not read; counter clears on each new command.
- Not defined: no counter, polling continues indefinitely, rsp_err tied 0.

## Test plan
- Reset, then cmd_arg=32'h4 with slave model clearing S[0] after 3 polls -> swr pulse at ADDR_A with sdata_in=4, exactly 3 S reads at 16'h2A0, one read at 16'h298, rsp_data equals model W, rsp_err=0.
- S[0]=0 on first poll, POLL_GAP=8 -> rsp_valid asserted exactly 17 cycles after acceptance.
- rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable throughout; cmd_ready stays 0; second cmd_valid ignored.
- reset asserted during GAP of an active command -> next cycle srd=swr=0, rsp_valid=0, busy=0; fresh command cmd_arg=32'h14 completes normally.
- With GPIOEMU_HOST_TIMEOUT_EN, TIMEOUT=200, S stuck at 1 -> rsp_err=1, rsp_data=0, no access to 16'h298; without the macro, polling continues past 2000 cycles.
- Bus checker throughout: srd/swr never coincide, each strobe one cycle wide, saddress stable from SETUP through HOLD/SAMPLE.
